// File: rtl/fetch_ram_pp_1p_pkg.sv
// Shared definitions for the fetch-stage ping-pong buffer.
//   FETCH_PP_BANKS : number of SRAM banks in the ping-pong pair
//   RAM_EN/RAM_DIS : active-low SRAM control encodings (cen/wen/oen)
//   lvl_t          : fill level, number of full banks (0..2)
package fetch_ram_pp_1p_pkg;

  localparam int   FETCH_PP_BANKS = 2;
  localparam logic RAM_EN         = 1'b0;
  localparam logic RAM_DIS        = 1'b1;

  typedef logic [1:0] lvl_t;

  localparam lvl_t LVL_EMPTY = 2'd0;
  localparam lvl_t LVL_FULL  = 2'd2;

  // Next fill level from a legal hand-over on either side; both together
  // cancel out.
  function automatic lvl_t lvl_next(lvl_t cur, logic inc, logic dec);
    lvl_t nxt;
    case ({inc, dec})
      2'b10:   nxt = cur + 2'd1;
      2'b01:   nxt = cur - 2'd1;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/fetch_ram_pp_1p_ctrl.sv
// Ping-pong bank controller: tracks write/read bank ownership, fill level
// and the sticky protocol-error flag, and produces per-bank SRAM controls.
//   clk, rst              : clock, async active-high reset
//   wr_val_i/wr_addr_i    : producer write strobe and address
//   wr_done_i             : producer hands the current write bank over
//   rd_req_i/rd_addr_i    : consumer read request and address
//   rd_done_i             : consumer releases the current read bank
//   wr_rdy_o/rd_rdy_o     : a bank is free / a full bank is available
//   lvl_o, err_o          : fill level, sticky protocol error
//   rd_val_o, rd_bank_o   : read data valid and the bank it came from
//   bank_cen/wen/oen_o    : per-bank active-low SRAM controls
//   bank_addr_o           : per-bank address
module fetch_ram_pp_ctrl
  import fetch_ram_pp_1p_pkg::*;
#(
  parameter int Addr_Width = 5
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         wr_val_i,
  input  logic [Addr_Width-1:0]                        wr_addr_i,
  input  logic                                         wr_done_i,
  input  logic                                         rd_req_i,
  input  logic [Addr_Width-1:0]                        rd_addr_i,
  input  logic                                         rd_done_i,
  output logic                                         wr_rdy_o,
  output logic                                         rd_rdy_o,
  output logic [1:0]                                   lvl_o,
  output logic                                         err_o,
  output logic                                         rd_val_o,
  output logic                                         rd_bank_o,
  output logic [FETCH_PP_BANKS-1:0]                    bank_cen_o,
  output logic [FETCH_PP_BANKS-1:0]                    bank_wen_o,
  output logic [FETCH_PP_BANKS-1:0]                    bank_oen_o,
  output logic [FETCH_PP_BANKS-1:0][Addr_Width-1:0]    bank_addr_o
);

  logic wbank_q, wbank_d;
  logic rbank_q, rbank_d;
  lvl_t cnt_q,   cnt_d;
  logic err_q,   err_d;
  logic rd_val_q, rd_val_d;
  logic rd_bank_q, rd_bank_d;

  logic wr_ok, rd_ok;
  logic wr_acc, rd_acc;
  logic wr_swap, rd_swap;

  assign wr_ok   = (cnt_q != LVL_FULL);
  assign rd_ok   = (cnt_q != LVL_EMPTY);
  assign wr_acc  = wr_val_i  && wr_ok;
  assign rd_acc  = rd_req_i  && rd_ok;
  assign wr_swap = wr_done_i && wr_ok;
  assign rd_swap = rd_done_i && rd_ok;

  always_comb begin
    wbank_d   = wbank_q ^ wr_swap;
    rbank_d   = rbank_q ^ rd_swap;
    cnt_d     = lvl_next(cnt_q, wr_swap, rd_swap);
    err_d     = err_q
              | (wr_val_i  && !wr_ok) | (wr_done_i && !wr_ok)
              | (rd_req_i  && !rd_ok) | (rd_done_i && !rd_ok);
    rd_val_d  = rd_acc;
    // Remember which bank the request went to; a same-cycle rd_done_i
    // must not redirect the returning data.
    rd_bank_d = rd_acc ? rbank_q : rd_bank_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbank_q   <= 1'b0;
      rbank_q   <= 1'b0;
      cnt_q     <= LVL_EMPTY;
      err_q     <= 1'b0;
      rd_val_q  <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      wbank_q   <= wbank_d;
      rbank_q   <= rbank_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      rd_val_q  <= rd_val_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  // With one full bank the two pointers differ, so a bank never sees a
  // read and a write together; at 0 or 2 only one side is enabled.
  always_comb begin
    for (int b = 0; b < FETCH_PP_BANKS; b++) begin
      logic wsel, rsel;
      wsel = wr_acc && (wbank_q == 1'(b));
      rsel = rd_acc && (rbank_q == 1'(b));
      bank_cen_o[b]  = (wsel || rsel) ? RAM_EN : RAM_DIS;
      bank_wen_o[b]  = wsel ? RAM_EN : RAM_DIS;
      bank_oen_o[b]  = rsel ? RAM_EN : RAM_DIS;
      bank_addr_o[b] = wsel ? wr_addr_i : rd_addr_i;
    end
  end

  assign wr_rdy_o  = wr_ok;
  assign rd_rdy_o  = rd_ok;
  assign lvl_o     = cnt_q;
  assign err_o     = err_q;
  assign rd_val_o  = rd_val_q;
  assign rd_bank_o = rd_bank_q;

endmodule

// File: rtl/ram_1p.sv
// Single-port synchronous SRAM model with active-low controls.
//   clk     : clock
//   cen_i   : chip enable (RAM_EN = access this cycle)
//   wen_i   : write enable (RAM_EN = write, RAM_DIS = read)
//   oen_i   : output enable for reads (RAM_EN = capture read data)
//   addr_i  : word address
//   d_i     : write data
//   q_o     : read data, valid the cycle after a read access
module ram_1p
  import fetch_ram_pp_1p_pkg::*;
#(
  parameter int Word_Width = 128,
  parameter int Addr_Width = 5
) (
  input  logic                  clk,
  input  logic                  cen_i,
  input  logic                  wen_i,
  input  logic                  oen_i,
  input  logic [Addr_Width-1:0] addr_i,
  input  logic [Word_Width-1:0] d_i,
  output logic [Word_Width-1:0] q_o
);

  localparam int Depth = 1 << Addr_Width;

  logic [Word_Width-1:0] mem_q [Depth];
  logic [Word_Width-1:0] q_q;

  // Storage carries no reset: contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (cen_i == RAM_EN) begin
      if (wen_i == RAM_EN) begin
        mem_q[addr_i] <= d_i;
      end else if (oen_i == RAM_EN) begin
        q_q <= mem_q[addr_i];
      end
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_ram_pp_1p.sv
// Fetch-stage ping-pong buffer over two single-port SRAM banks. The
// producer fills one bank while the consumer reads the other.
//   clk, rst                       : clock, async active-high reset
//   wr_rdy_o                       : a bank is free for filling
//   wr_val_i/wr_addr_i/wr_dat_i    : write into the current write bank
//   wr_done_i                      : hand the write bank to the reader
//   rd_rdy_o                       : a full bank is available
//   rd_req_i/rd_addr_i             : read from the current read bank
//   rd_done_i                      : release the read bank to the writer
//   rd_val_o/rd_dat_o              : read data, one cycle after request
//   lvl_o                          : number of full banks
//   err_o                          : sticky protocol error
module fetch_ram_pp_1p
  import fetch_ram_pp_1p_pkg::*;
#(
  parameter int Word_Width = 128,
  parameter int Addr_Width = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  wr_rdy_o,
  input  logic                  wr_val_i,
  input  logic [Addr_Width-1:0] wr_addr_i,
  input  logic [Word_Width-1:0] wr_dat_i,
  input  logic                  wr_done_i,
  output logic                  rd_rdy_o,
  input  logic                  rd_req_i,
  input  logic [Addr_Width-1:0] rd_addr_i,
  input  logic                  rd_done_i,
  output logic                  rd_val_o,
  output logic [Word_Width-1:0] rd_dat_o,
  output logic [1:0]            lvl_o,
  output logic                  err_o
);

  logic                                       rd_bank;
  logic [FETCH_PP_BANKS-1:0]                  bank_cen;
  logic [FETCH_PP_BANKS-1:0]                  bank_wen;
  logic [FETCH_PP_BANKS-1:0]                  bank_oen;
  logic [FETCH_PP_BANKS-1:0][Addr_Width-1:0]  bank_addr;
  logic [Word_Width-1:0]                      bank_q [FETCH_PP_BANKS];

  fetch_ram_pp_ctrl #(
    .Addr_Width (Addr_Width)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .wr_val_i    (wr_val_i),
    .wr_addr_i   (wr_addr_i),
    .wr_done_i   (wr_done_i),
    .rd_req_i    (rd_req_i),
    .rd_addr_i   (rd_addr_i),
    .rd_done_i   (rd_done_i),
    .wr_rdy_o    (wr_rdy_o),
    .rd_rdy_o    (rd_rdy_o),
    .lvl_o       (lvl_o),
    .err_o       (err_o),
    .rd_val_o    (rd_val_o),
    .rd_bank_o   (rd_bank),
    .bank_cen_o  (bank_cen),
    .bank_wen_o  (bank_wen),
    .bank_oen_o  (bank_oen),
    .bank_addr_o (bank_addr)
  );

  for (genvar b = 0; b < FETCH_PP_BANKS; b++) begin : g_bank
    ram_1p #(
      .Word_Width (Word_Width),
      .Addr_Width (Addr_Width)
    ) u_ram (
      .clk    (clk),
      .cen_i  (bank_cen[b]),
      .wen_i  (bank_wen[b]),
      .oen_i  (bank_oen[b]),
      .addr_i (bank_addr[b]),
      .d_i    (wr_dat_i),
      .q_o    (bank_q[b])
    );
  end

  // SRAM output registers hold stale data between reads; mask them.
  assign rd_dat_o = rd_val_o ? bank_q[rd_bank] : '0;

endmodule

// File: tb/tb_fetch_ram_pp_1p.sv
module tb_fetch_ram_pp_1p;

  localparam int WW    = 128;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_rdy_o;
  logic          wr_val_i;
  logic [AW-1:0] wr_addr_i;
  logic [WW-1:0] wr_dat_i;
  logic          wr_done_i;
  logic          rd_rdy_o;
  logic          rd_req_i;
  logic [AW-1:0] rd_addr_i;
  logic          rd_done_i;
  logic          rd_val_o;
  logic [WW-1:0] rd_dat_o;
  logic [1:0]    lvl_o;
  logic          err_o;

  fetch_ram_pp_1p #(.Word_Width(WW), .Addr_Width(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_rdy_o  (wr_rdy_o),
    .wr_val_i  (wr_val_i),
    .wr_addr_i (wr_addr_i),
    .wr_dat_i  (wr_dat_i),
    .wr_done_i (wr_done_i),
    .rd_rdy_o  (rd_rdy_o),
    .rd_req_i  (rd_req_i),
    .rd_addr_i (rd_addr_i),
    .rd_done_i (rd_done_i),
    .rd_val_o  (rd_val_o),
    .rd_dat_o  (rd_dat_o),
    .lvl_o     (lvl_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  // reference model
  logic [WW-1:0] mdl_mem [2][DEPTH];
  logic          m_wbank, m_rbank, m_err;
  logic [1:0]    m_cnt;
  logic [WW-1:0] sb_q [$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status();
    chk("lvl",    WW'(lvl_o),    WW'(m_cnt));
    chk("wr_rdy", WW'(wr_rdy_o), WW'(m_cnt != 2'd2));
    chk("rd_rdy", WW'(rd_rdy_o), WW'(m_cnt != 2'd0));
    chk("err",    WW'(err_o),    WW'(m_err));
  endtask

  // One clock: update the model from the driven inputs, clock the DUT,
  // then compare outputs against the model and scoreboard.
  task automatic cyc();
    logic wr_ok, rd_ok, pushed, wsw, rsw;
    wr_ok  = (m_cnt != 2'd2);
    rd_ok  = (m_cnt != 2'd0);
    pushed = 1'b0;
    if (rd_req_i) begin
      if (rd_ok) begin
        sb_q.push_back(mdl_mem[m_rbank][rd_addr_i]);
        pushed = 1'b1;
      end else m_err = 1'b1;
    end
    if (wr_val_i) begin
      if (wr_ok) mdl_mem[m_wbank][wr_addr_i] = wr_dat_i;
      else m_err = 1'b1;
    end
    wsw = wr_done_i && wr_ok;
    rsw = rd_done_i && rd_ok;
    if (wr_done_i && !wr_ok) m_err = 1'b1;
    if (rd_done_i && !rd_ok) m_err = 1'b1;
    if (wsw) m_wbank = ~m_wbank;
    if (rsw) m_rbank = ~m_rbank;
    m_cnt = m_cnt + {1'b0, wsw} - {1'b0, rsw};

    @(posedge clk);
    #1;
    chk("rd_val", WW'(rd_val_o), WW'(pushed));
    if (rd_val_o && sb_q.size() > 0) chk("rd_dat", rd_dat_o, sb_q.pop_front());
    else chk("rd_dat_idle", rd_dat_o, '0);
    if (!rd_val_o) sb_q.delete();
    chk_status();
  endtask

  task automatic drive(input logic wv, input int wa, input logic [WW-1:0] wd, input logic wdn,
                       input logic rq, input int ra, input logic rdn);
    wr_val_i  = wv;
    wr_addr_i = AW'(wa);
    wr_dat_i  = wd;
    wr_done_i = wdn;
    rd_req_i  = rq;
    rd_addr_i = AW'(ra);
    rd_done_i = rdn;
    cyc();
    wr_val_i  = 1'b0;
    wr_done_i = 1'b0;
    rd_req_i  = 1'b0;
    rd_done_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_wbank = 1'b0;
    m_rbank = 1'b0;
    m_cnt   = 2'd0;
    m_err   = 1'b0;
    sb_q.delete();
    chk("rst_rd_val", WW'(rd_val_o), '0);
    chk("rst_rd_dat", rd_dat_o, '0);
    chk_status();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic fill(input logic [WW-1:0] base);
    for (int a = 0; a < DEPTH; a++) drive(1'b1, a, base + WW'(a), 1'b0, 1'b0, 0, 1'b0);
    drive(1'b0, 0, '0, 1'b1, 1'b0, 0, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    wr_val_i  = 1'b0;
    wr_addr_i = '0;
    wr_dat_i  = '0;
    wr_done_i = 1'b0;
    rd_req_i  = 1'b0;
    rd_addr_i = '0;
    rd_done_i = 1'b0;
    do_reset();

    // fill bank 0, hand it over, read address 5
    fill(WW'('h100));
    chk("lvl_after_fill", WW'(lvl_o), WW'(1));
    drive(1'b0, 0, '0, 1'b0, 1'b1, 5, 1'b0);
    chk("rd_addr5", rd_dat_o, WW'('h105));

    // fill bank 1 while reading bank 0 every cycle
    for (int a = 0; a < DEPTH; a++)
      drive(1'b1, a, WW'('h200 + a), 1'b0, 1'b1, (a * 7) % DEPTH, 1'b0);
    drive(1'b0, 0, '0, 1'b1, 1'b0, 0, 1'b0);
    chk("lvl_full", WW'(lvl_o), WW'(2));
    chk("wr_rdy_full", WW'(wr_rdy_o), '0);
    drive(1'b1, 3, WW'('hdead), 1'b0, 1'b0, 0, 1'b0);
    chk("err_wr_drop", WW'(err_o), WW'(1));

    // release bank 0, refill part of it while reading bank 1
    drive(1'b0, 0, '0, 1'b0, 1'b0, 0, 1'b1);
    for (int a = 0; a < 8; a++)
      drive(1'b1, a, WW'('h300 + a), 1'b0, 1'b1, a + 20, 1'b0);
    // simultaneous hand-over on both sides, with a read in the same cycle
    drive(1'b0, 0, '0, 1'b1, 1'b1, 9, 1'b1);
    chk("lvl_swap", WW'(lvl_o), WW'(1));
    drive(1'b0, 0, '0, 1'b0, 1'b1, 3, 1'b0);
    chk("rd_new_bank", rd_dat_o, WW'('h303));
    drive(1'b0, 0, '0, 1'b0, 1'b1, 10, 1'b0);

    // err clears only on reset; rd_done_i on empty sets it
    do_reset();
    drive(1'b0, 0, '0, 1'b0, 1'b0, 0, 1'b1);
    chk("err_rd_done_empty", WW'(err_o), WW'(1));
    drive(1'b0, 0, '0, 1'b0, 1'b1, 0, 1'b0);
    do_reset();

    // reset mid-burst with both banks full and a read in flight
    fill(WW'('h400));
    fill(WW'('h500));
    drive(1'b0, 0, '0, 1'b0, 1'b1, 7, 1'b0);
    chk("rd_full_b0", rd_dat_o, WW'('h407));
    rd_req_i  = 1'b1;
    rd_addr_i = AW'(2);
    @(posedge clk);
    #1;
    rd_req_i = 1'b0;
    chk("inflight_val", WW'(rd_val_o), WW'(1));
    do_reset();

    // first write after reset lands in bank 0
    drive(1'b1, 0, WW'('habc), 1'b0, 1'b0, 0, 1'b0);
    drive(1'b0, 0, '0, 1'b1, 1'b0, 0, 1'b0);
    drive(1'b0, 0, '0, 1'b0, 1'b1, 0, 1'b0);
    chk("post_rst_bank0", rd_dat_o, WW'('habc));
    drive(1'b0, 0, '0, 1'b0, 1'b1, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ram_pp_1p.md
Name: fetch_ram_pp_1p

Overview:
- Parametrised ping-pong buffer for the fetch stage. Built from two single-port SRAM banks (ram_1p instances).
- The producer (external-memory load engine) fills one bank while the consumer (prediction/ME engines) reads the other.
- Bank ownership, fill level and swap handshakes are tracked internally, so neither side arbitrates SRAM ports itself.

Parameters:
- Word_Width, 128, data width of each SRAM word.
- Addr_Width, 5, address width per bank; depth = 2**Addr_Width words.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wr_rdy_o  out  1  a bank is free for filling
- wr_val_i  in  1  write strobe
- wr_addr_i  in  Addr_Width  write address within current write bank
- wr_dat_i  in  Word_Width  write data
- wr_done_i  in  1  current write bank complete; hand it to the reader
- rd_rdy_o  out  1  a full bank is available for reading
- rd_req_i  in  1  read request
- rd_addr_i  in  Addr_Width  read address within current read bank
- rd_val_o  out  1  rd_dat_o valid
- rd_dat_o  out  Word_Width  read data
- lvl_o  out  2  number of full banks (0..2)
- err_o  out  1  sticky protocol-error flag

Behaviour:
- State: wbank (1 bit), rbank (1 bit), cnt (2 bits, 0..2).
- Reset: wbank=0, rbank=0, cnt=0, rd_val_o=0, err_o=0, rd_dat_o=0. Asserting reset mid-operation discards all bank contents logically; SRAM contents are not cleared.
- wr_rdy_o = (cnt != 2). rd_rdy_o = (cnt != 0). lvl_o = cnt. All combinational from registers.
- Write: when wr_val_i && wr_rdy_o, bank[wbank] gets cen=0, wen=0 at wr_addr_i in the same cycle. wr_val_i while !wr_rdy_o is dropped (no SRAM access) and sets err_o.
- Read: when rd_req_i && rd_rdy_o, bank[rbank] gets cen=0, wen=1, oen=0 at rd_addr_i. On the next cycle, rd_val_o=1 and rd_dat_o = bank[rbank_q] output, where rbank_q is rbank registered at request time. Latency is exactly 1 cycle. rd_req_i while !rd_rdy_o is ignored and sets err_o.
- rd_dat_o is forced to 0 whenever rd_val_o=0.
- SRAM control is active-low (cen/wen/oen = 0 means enable/write/output). Idle banks are held at cen=1, wen=1, oen=1.
- Port exclusivity: writes need cnt<2 and reads need cnt>0.
  - When cnt==1, wbank != rbank by construction, so no bank ever sees read and write in the same cycle.
  - When cnt==0 or cnt==2, only one side is enabled.
- wr_done_i with cnt<2: wbank toggles, cnt+1. A write accepted in the same cycle lands in the old bank.
- rd_done_i with cnt>0: rbank toggles, cnt-1. A read accepted in the same cycle uses the old bank; its data returns next cycle from the old bank.
- wr_done_i and rd_done_i together (both legal): both pointers toggle and cnt is unchanged.
- wr_done_i at cnt==2, or rd_done_i at cnt==0: ignored (no pointer or cnt change) and sets err_o.
- err_o is cleared only by rst.
- No combinational path from inputs to wr_rdy_o, rd_rdy_o or lvl_o.

Decomposition:
- Shared package (fetch_defines include):
  - bank-count constant FETCH_PP_BANKS=2
  - SRAM control encodings RAM_EN=0 / RAM_DIS=1
  - 2-bit level type
- One sub-module, fetch_ram_pp_ctrl: wbank, rbank, cnt, err and the acceptance logic; outputs per-bank cen/wen/oen/addr selects.
- Top instantiates the controller and two ram_1p, and muxes the read data.

Test Plan:
- Reset → wr_rdy_o=1, rd_rdy_o=0, lvl_o=0, rd_val_o=0, err_o=0.
- Fill 32 words (data = addr+0x100) then wr_done_i → lvl_o=1, rd_rdy_o=1. Read addr 5 → one cycle later rd_val_o=1, rd_dat_o=0x105.
- Fill bank 1 while reading bank 0 concurrently every cycle → all reads return bank-0 data with no corruption. Second wr_done_i → lvl_o=2, wr_rdy_o=0. Write attempt then → dropped, err_o=1.
- cnt=1: pulse wr_done_i and rd_done_i in the same cycle → lvl_o stays 1, both banks swap. Next read returns the newly filled data.
- rd_done_i at lvl_o=0 → ignored, lvl_o stays 0, err_o=1. Assert rst → err_o=0.
- Assert rst mid-burst with lvl_o=2 and a read in flight → rd_val_o=0 and lvl_o=0 immediately (asynchronous). First write after release goes to bank 0.
